// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl opcodes and multiply-sequencer state codes.
// Consumed by ALU_Control, ALU and mul_sequencer.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_RUN  = 2'd1,
        MS_DONE = 2'd2
    } ms_state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: retires BPC multiplier bits into the accumulator.
// Purely combinational; everything is modulo 2^WIDTH.
module mul_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mcand_nxt,
    output logic [WIDTH-1:0] mplier_nxt
);

    // part[i] = acc plus the partial products of multiplier bits below i
    logic [BPC:0][WIDTH-1:0] part;

    assign part[0] = acc;

    for (genvar i = 0; i < BPC; i++) begin : g_bit
        assign part[i+1] = part[i] + (mplier[i] ? (mcand << i) : '0);
    end

    assign acc_nxt    = part[BPC];
    assign mcand_nxt  = mcand << BPC;
    assign mplier_nxt = mplier >> BPC;

endmodule

// File: rtl/mul_sequencer.sv
// EX-stage multi-cycle multiply controller: stalls the front end while an
// iterative shift-add runs, then presents the product for one done_o cycle.
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BPC       = 1,     // 1, 2 or 4; must divide WIDTH
    parameter bit EARLY_OUT = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);

    localparam int STEPS = WIDTH / BPC;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    ms_state_e        state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] acc_nxt, mcand_nxt, mplier_nxt;
    logic             start, last_step;

    assign start = valid_i && (ALUCtrl_i == ALU_MUL) && !flush_i;

    // Early-out looks at the multiplier after this step's shift.
    assign last_step = (count == LAST) || (EARLY_OUT && (mplier_nxt == '0));

    mul_step #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier     (mplier),
        .acc_nxt    (acc_nxt),
        .mcand_nxt  (mcand_nxt),
        .mplier_nxt (mplier_nxt)
    );

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        unique case (state)
            MS_IDLE: begin
                stall_o = start;
                if (start) state_nxt = MS_RUN;
            end
            MS_RUN: begin
                stall_o = 1'b1;
                if (flush_i)        state_nxt = MS_IDLE;
                else if (last_step) state_nxt = MS_DONE;
            end
            MS_DONE: state_nxt = MS_IDLE;
            default: state_nxt = MS_IDLE;
        endcase
        if (rst_i) stall_o = 1'b0;
    end

    // A flush in DONE does not cancel the pulse: the result is already committed.
    assign done_o = (state == MS_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= MS_IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            data_o <= '0;
            Zero_o <= 1'b1;
        end else begin
            state <= state_nxt;
            case (state)
                MS_IDLE: if (start) begin
                    mcand  <= data1_i;
                    mplier <= data2_i;
                    acc    <= '0;
                    count  <= '0;
                end
                MS_RUN: if (!flush_i) begin
                    acc    <= acc_nxt;
                    mcand  <= mcand_nxt;
                    mplier <= mplier_nxt;
                    count  <= count + CW'(1);
                    if (last_step) begin
                        data_o <= acc_nxt;
                        Zero_o <= (acc_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomised scoreboard bench for mul_sequencer: the driver plays the EX stage,
// the monitor checks stall/done timing and the held product against a plain-arithmetic model.
module tb_mul_sequencer;

    localparam int W   = 32;
    localparam int BPC = 2;
    localparam bit EO  = 1'b1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef struct {
        logic [W-1:0] p;
        int           due;
    } exp_t;

    logic         clk = 1'b0, rst = 1'b1, valid = 1'b0, flush = 1'b0;
    logic [2:0]   ctrl = 3'b000;
    logic [W-1:0] d1 = '0, d2 = '0;
    logic         stall, done, zero;
    logic [W-1:0] dout;

    int           cyc = 0, n_vec = 0, n_err = 0;
    logic         exp_stall = 1'b0;
    logic [W-1:0] hold_d = '0;
    logic         hold_z = 1'b1;
    exp_t         q[$];
    logic [2:0]   non_mul[4] = '{OP_AND, OP_OR, OP_ADD, OP_SUB};

    mul_sequencer #(.WIDTH(W), .BPC(BPC), .EARLY_OUT(EO)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .ALUCtrl_i (ctrl),
        .flush_i   (flush),
        .data1_i   (d1),
        .data2_i   (d2),
        .stall_o   (stall),
        .done_o    (done),
        .data_o    (dout),
        .Zero_o    (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Cycles spent in RUN: one per BPC-bit digit, cut short once the rest is zero.
    function automatic int ref_steps(input logic [W-1:0] b);
        int n;
        logic [W-1:0] m;
        if (!EO) return W / BPC;
        n = 1;
        m = b >> BPC;
        while (m != 0) begin
            n++;
            m = m >> BPC;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        chk("stall_o", W'(stall), W'(exp_stall));
        if (rst) begin
            hold_d = '0;
            hold_z = 1'b1;
        end else if (done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", W'(cyc), W'(e.due));
                chk("data_o", dout, e.p);
                chk("Zero_o", W'(zero), W'(e.p == '0));
                hold_d = e.p;
                hold_z = (e.p == '0);
            end
        end else begin
            if (q.size() > 0 && cyc > q[0].due) begin
                chk("done_timeout", W'(cyc), W'(q[0].due));
                void'(q.pop_front());
            end
            chk("data_hold", dout, hold_d);
            chk("zero_hold", W'(zero), W'(hold_z));
        end
    end

    task automatic next_cycle(input logic es);
        exp_stall = es;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in EX and keep it there for as long as the
    // sequencer stalls. abort_at = RUN cycle (1-based) to flush/reset on, 0 = none.
    task automatic issue(input logic [2:0] op, input logic v, input logic fl,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int abort_at, input bit abort_rst, input bit done_flush);
        int   steps;
        exp_t e;
        valid = v; ctrl = op; flush = fl; d1 = a; d2 = b;
        if (!(v && op == OP_MUL && !fl)) begin
            next_cycle(1'b0);
            return;
        end
        steps = ref_steps(b);
        if (abort_at == 0 || abort_at > steps) begin
            e.p   = a * b;
            e.due = cyc + steps + 1;
            q.push_back(e);
        end
        next_cycle(1'b1);
        for (int k = 1; k <= steps; k++) begin
            d1 = $urandom;
            d2 = $urandom;
            if (k == abort_at) begin
                if (abort_rst) begin
                    rst = 1'b1;
                    next_cycle(1'b0);
                    rst = 1'b0;
                end else begin
                    flush = 1'b1;
                    next_cycle(1'b1);
                    flush = 1'b0;
                end
                return;
            end
            next_cycle(1'b1);
        end
        flush = done_flush;
        next_cycle(1'b0);
        flush = 1'b0;
    endtask

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic         v, fl;
        int           ab;
        bit           ar, dfl;

        repeat (3) next_cycle(1'b0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) issue(OP_ADD, 1'b1, 1'b0, $urandom, $urandom, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'd6, 32'd7, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd3, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'd5, 32'd1, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'd9, 32'd9, 0, 0, 1);
        issue(OP_MUL, 1'b1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 10, 0, 0);
        issue(OP_MUL, 1'b1, 1'b1, 32'd3, 32'd3, 0, 0, 0);
        issue(OP_MUL, 1'b0, 1'b0, 32'd3, 32'd3, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 10, 1, 0);
        issue(OP_SUB, 1'b1, 1'b0, 32'd1, 32'd1, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'd2, 32'd3, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'd4, 32'd5, 0, 0, 0);
        issue(OP_MUL, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);

        for (int t = 0; t < 300; t++) begin
            op = ($urandom_range(0, 9) < 5) ? OP_MUL : non_mul[$urandom_range(0, 3)];
            v  = ($urandom_range(0, 99) < 85);
            fl = ($urandom_range(0, 9) == 0);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = W'($urandom_range(0, 255));
                2:       b = '0;
                default: b = W'(1) << $urandom_range(0, W - 1);
            endcase
            ab = 0;
            ar = 1'b0;
            case ($urandom_range(0, 19))
                0, 1: ab = $urandom_range(1, ref_steps(b));
                2: begin
                    ab = $urandom_range(1, ref_steps(b));
                    ar = 1'b1;
                end
                default: ;
            endcase
            dfl = ($urandom_range(0, 2) == 0);
            issue(op, v, fl, a, b, ab, ar, dfl);
        end

        valid = 1'b0;
        repeat (5) next_cycle(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
